uart_rx_core: RTL

Parametrised UART receive engine, successor to the fixed-format receive FSM.
- Oversampled serial input; mid-bit sampling; configurable data width, parity mode and stop-bit count.
- Delivers each received character with parity and framing status as a one-cycle valid pulse.
- Sits between the pad-side rxd line and the receive FIFO / register interface; baud_tick comes from the shared baud generator.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: parity mode codes and receive FSM state encoding.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_BREAK  = 3'd5;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous serial line; resets to the idle-high level.
module uart_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: mid-bit sampling, optional parity, 1 or 2 checked stop bits.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample
// START  | half a bit period to the middle of the start bit
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling STOP_BITS stop bits; last one completes the frame
// BREAK  | line held low after a framing error, wait for high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic PAR_ODD = (PARITY_MODE == PARITY_ODD);

    logic                 rxd_s;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    uart_sync2 u_sync (
        .clk_i   (clk),
        .rst_n_i (reset),
        .d_i     (rxd),
        .q_o     (rxd_s)
    );

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (baud_tick) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        state_d = RX_START;
                        tick_d  = '0;
                    end
                end
                RX_START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (!rxd_s) begin
                            state_d = RX_DATA;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                RX_PARITY: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        perr_d  = ((^shift_q) ^ rxd_s) != PAR_ODD;
                        state_d = RX_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (bit_q == STOP_LAST) begin
                            // Frame completes here; a low final stop means the line may be in break.
                            bit_d        = '0;
                            rx_data_d    = shift_q;
                            parity_err_d = perr_q;
                            frame_err_d  = ferr_q | ~rxd_s;
                            rx_valid_d   = 1'b1;
                            state_d      = rxd_s ? RX_IDLE : RX_BREAK;
                        end else begin
                            ferr_d = ferr_q | ~rxd_s;
                            bit_d  = bit_q + 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                RX_BREAK: begin
                    if (rxd_s) begin
                        state_d = RX_IDLE;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RX_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != RX_IDLE) && (state_q != RX_BREAK);

endmodule
